// File: rtl/spi_mem_master.sv
// SPI mode-0 initiator for single-byte memory reads and writes.
// It sends one 16-bit frame {addr, read_write, data} MSB first and returns the read byte in parallel.
module spi_mem_master #(
  parameter int HALF_PERIOD = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic       read_write,
  input  logic [7:0] wdata,
  input  logic       miso,
  output logic       s_clk,
  output logic       mosi,
  output logic       cs,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata
);

  localparam logic [7:0] HP_LAST = 8'(HALF_PERIOD - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, DONE, GAP} state_t;

  state_t      state, state_nxt;
  logic [7:0]  hp_cnt, hp_cnt_nxt;
  logic [3:0]  bit_cnt, bit_cnt_nxt;
  logic        sclk_nxt;
  logic        hp_end;
  logic        load, rise, fall, finish;
  logic [15:0] tx_sr;
  logic [7:0]  rx_sr;
  logic        rw_lat;

  assign hp_end = (hp_cnt == HP_LAST);
  assign mosi   = tx_sr[15];

  always_comb begin
    state_nxt   = state;
    hp_cnt_nxt  = hp_cnt + 8'd1;
    bit_cnt_nxt = bit_cnt;
    sclk_nxt    = s_clk;
    load        = 1'b0;
    rise        = 1'b0;
    fall        = 1'b0;
    finish      = 1'b0;
    unique case (state)
      IDLE: begin
        hp_cnt_nxt = '0;
        if (start) begin
          state_nxt = SETUP;
          load      = 1'b1;
        end
      end
      SETUP: begin
        if (hp_end) begin
          state_nxt  = SHIFT;
          hp_cnt_nxt = '0;
          sclk_nxt   = 1'b1;
          rise       = 1'b1;
        end
      end
      SHIFT: begin
        if (hp_end) begin
          hp_cnt_nxt = '0;
          if (s_clk) begin
            sclk_nxt = 1'b0;
            fall     = 1'b1;
          end else if (bit_cnt == 4'd15) begin
            // Sixteenth low half finished: the frame is complete.
            state_nxt   = DONE;
            bit_cnt_nxt = '0;
            finish      = 1'b1;
          end else begin
            sclk_nxt    = 1'b1;
            rise        = 1'b1;
            bit_cnt_nxt = bit_cnt + 4'd1;
          end
        end
      end
      DONE: begin
        state_nxt  = GAP;
        hp_cnt_nxt = '0;
      end
      GAP: begin
        if (hp_end) begin
          state_nxt  = IDLE;
          hp_cnt_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so cs and s_clk never glitch.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      hp_cnt  <= '0;
      bit_cnt <= '0;
      s_clk   <= 1'b0;
      cs      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      rdata   <= 8'h00;
      tx_sr   <= '0;
    end else begin
      state   <= state_nxt;
      hp_cnt  <= hp_cnt_nxt;
      bit_cnt <= bit_cnt_nxt;
      s_clk   <= sclk_nxt;
      cs      <= !((state_nxt == SETUP) || (state_nxt == SHIFT));
      busy    <= (state_nxt != IDLE);
      done    <= finish;
      if (finish && rw_lat) rdata <= rx_sr;
      if (load) tx_sr <= {addr, read_write, (read_write ? 8'h00 : wdata)};
      else if (fall) tx_sr <= {tx_sr[14:0], 1'b0};
    end
  end

  // The last eight rises (the data phase) are left in rx_sr when the frame ends.
  always_ff @(posedge clk) begin
    if (load) rw_lat <= read_write;
    if (rise) rx_sr <= {rx_sr[6:0], miso};
  end

endmodule

// File: tb/tb_spi_mem_master.sv
// Bench for spi_mem_master: instance 0 uses HALF_PERIOD=4, instance 1 uses HALF_PERIOD=1.
// Each instance has a mode-0 responder model and a scoreboard of expected frames and read bytes.
module tb_spi_mem_master;

  typedef struct {
    logic [15:0] frame;
    logic [7:0]  rdata;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start [2];
  logic [6:0] addr [2];
  logic       read_write [2];
  logic [7:0] wdata [2];
  logic       miso [2];
  logic       s_clk [2];
  logic       mosi [2];
  logic       cs [2];
  logic       busy [2];
  logic       done [2];
  logic [7:0] rdata [2];
  logic [7:0] resp [2];
  logic [7:0] mdl_rdata [2];

  exp_t sb0[$];
  exp_t sb1[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   proto_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int i, input logic [6:0] a, input logic rw,
                          input logic [7:0] wd, input logic [7:0] rb);
    exp_t e;
    if (rw) mdl_rdata[i] = rb;
    e.frame = {a, rw, (rw ? 8'h00 : wd)};
    e.rdata = mdl_rdata[i];
    if (i == 0) sb0.push_back(e);
    else sb1.push_back(e);
  endtask

  task automatic wait_busy(input int i, input logic lvl);
    int k = 0;
    while (busy[i] !== lvl && k < 500) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("wait_busy%0d_%0d", i, lvl), 32'(busy[i] === lvl), 32'd1);
  endtask

  // One transaction; inputs are scrambled every cycle after acceptance and
  // optionally start is pulsed at cycles 5 and 60 of the frame.
  task automatic run_frame(input int i, input logic [6:0] a, input logic rw,
                           input logic [7:0] wd, input logic [7:0] rb, input logic poke);
    int k;
    @(negedge clk);
    addr[i] = a;
    read_write[i] = rw;
    wdata[i] = wd;
    resp[i] = rb;
    start[i] = 1'b1;
    push_exp(i, a, rw, wd, rb);
    @(negedge clk);
    start[i] = 1'b0;
    k = 1;
    while (busy[i] === 1'b1 && k < 1000) begin
      addr[i] = 7'($urandom);
      read_write[i] = 1'($urandom);
      wdata[i] = 8'($urandom);
      start[i] = poke && (k == 5 || k == 60);
      @(negedge clk);
      k++;
    end
    start[i] = 1'b0;
    check($sformatf("frame_end%0d", i), 32'(k < 1000), 32'd1);
  endtask

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int H = (g == 0) ? 4 : 1;
    int          rise_n = 0;
    int          acc = 0;
    int          cs_low_n = 0;
    int          busy_n = 0;
    int          hi_run = 0;
    int          frames = 0;
    logic [15:0] cap = '0;
    logic        busy_d = 1'b0;
    logic        cs_d = 1'b1;
    logic        sclk_d = 1'b0;
    logic        mosi_d = 1'b0;
    logic        got_done = 1'b0;
    exp_t        e;

    spi_mem_master #(.HALF_PERIOD(H)) u_dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start[g]),
      .addr       (addr[g]),
      .read_write (read_write[g]),
      .wdata      (wdata[g]),
      .miso       (miso[g]),
      .s_clk      (s_clk[g]),
      .mosi       (mosi[g]),
      .cs         (cs[g]),
      .busy       (busy[g]),
      .done       (done[g]),
      .rdata      (rdata[g])
    );

    // Responder: data byte on rises 9..16, changed only after a rise.
    assign miso[g] = (rise_n >= 8 && rise_n < 16) ? resp[g][3'(15 - rise_n)] : 1'b0;

    always @(posedge s_clk[g] or negedge cs[g]) begin
      if (s_clk[g] === 1'b1) begin
        cap = {cap[14:0], mosi[g]};
        rise_n++;
      end else begin
        rise_n = 0;
        cap = '0;
      end
    end

    always @(negedge clk) begin
      if (busy[g] === 1'b1 && !busy_d) begin
        acc = cyc - 1;
        cs_low_n = 0;
        busy_n = 0;
        got_done = 1'b0;
      end
      if (busy[g] === 1'b1) busy_n++;
      if (cs[g] === 1'b0) cs_low_n++;
      if (cs[g] === 1'b1 && s_clk[g] !== 1'b0) proto_err++;
      if (s_clk[g] === 1'b1 && sclk_d && mosi[g] !== mosi_d) proto_err++;
      if (cs[g] === 1'b0 && cs_d) begin
        if (frames > 0) check($sformatf("cs_gap%0d", g), 32'(hi_run >= 2), 32'd1);
        hi_run = 0;
      end
      if (cs[g] === 1'b1) hi_run++;
      if (done[g] === 1'b1) begin
        if ((g == 0 ? sb0.size() : sb1.size()) == 0) begin
          check($sformatf("extra_done%0d", g), 32'd1, 32'd0);
        end else begin
          if (g == 0) e = sb0.pop_front();
          else e = sb1.pop_front();
          check($sformatf("rdata%0d", g), 32'(rdata[g]), 32'(e.rdata));
          check($sformatf("frame%0d", g), 32'(cap), 32'(e.frame));
          check($sformatf("done_lat%0d", g), 32'(cyc - acc), 32'(1 + 33 * H));
          check($sformatf("cs_low%0d", g), 32'(cs_low_n), 32'(33 * H));
          check($sformatf("cs_at_done%0d", g), 32'(cs[g]), 32'd1);
          got_done = 1'b1;
          frames++;
        end
      end
      if (busy[g] === 1'b0 && busy_d && got_done)
        check($sformatf("busy_len%0d", g), 32'(busy_n), 32'(34 * H + 1));
      busy_d = (busy[g] === 1'b1);
      cs_d   = (cs[g] === 1'b1);
      sclk_d = (s_clk[g] === 1'b1);
      mosi_d = (mosi[g] === 1'b1);
    end
  end

  initial begin
    int k;
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0;
      addr[i] = '0;
      read_write[i] = 1'b0;
      wdata[i] = '0;
      resp[i] = '0;
      mdl_rdata[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_cs%0d", i), 32'(cs[i]), 32'd1);
      check($sformatf("rst_sclk%0d", i), 32'(s_clk[i]), 32'd0);
      check($sformatf("rst_mosi%0d", i), 32'(mosi[i]), 32'd0);
      check($sformatf("rst_busy%0d", i), 32'(busy[i]), 32'd0);
      check($sformatf("rst_done%0d", i), 32'(done[i]), 32'd0);
      check($sformatf("rst_rdata%0d", i), 32'(rdata[i]), 32'd0);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    run_frame(0, 7'h2A, 1'b0, 8'hC5, 8'h00, 1'b0);
    run_frame(0, 7'h15, 1'b1, 8'h77, 8'hA6, 1'b1);

    // Abort a read at cycle 40 of the frame.
    @(negedge clk);
    addr[0] = 7'h33;
    read_write[0] = 1'b1;
    resp[0] = 8'h5A;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (39) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("abort_cs", 32'(cs[0]), 32'd1);
    check("abort_sclk", 32'(s_clk[0]), 32'd0);
    check("abort_busy", 32'(busy[0]), 32'd0);
    check("abort_done", 32'(done[0]), 32'd0);
    check("abort_rdata", 32'(rdata[0]), 32'd0);
    reset_n = 1'b1;
    mdl_rdata[0] = 8'h00;
    mdl_rdata[1] = 8'h00;
    @(negedge clk);
    run_frame(0, 7'h4E, 1'b1, 8'h99, 8'h3C, 1'b0);

    // Back-to-back frames with start held high at HALF_PERIOD=1.
    @(negedge clk);
    addr[1] = 7'h7F;
    read_write[1] = 1'b1;
    wdata[1] = 8'h5A;
    resp[1] = 8'hFF;
    start[1] = 1'b1;
    push_exp(1, 7'h7F, 1'b1, 8'h5A, 8'hFF);
    push_exp(1, 7'h00, 1'b0, 8'h01, 8'h00);
    wait_busy(1, 1'b1);
    addr[1] = 7'h00;
    read_write[1] = 1'b0;
    wdata[1] = 8'h01;
    wait_busy(1, 1'b0);
    wait_busy(1, 1'b1);
    start[1] = 1'b0;
    wait_busy(1, 1'b0);

    k = 0;
    while ((sb0.size() != 0 || sb1.size() != 0) && k < 500) begin
      @(negedge clk);
      k++;
    end
    repeat (4) @(negedge clk);
    check("sb0_left", 32'(sb0.size()), 32'd0);
    check("sb1_left", 32'(sb1.size()), 32'd0);
    check("proto_err", 32'(proto_err), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
